// File: rtl/uart_word_bridge.sv
// UART <-> word bridge: 8N1 RX packs BYTES received bytes into one word, TX serialises a word as BYTES frames.
// Latency: read strobe one cycle after the final stop-bit sample; TX busy for BYTES*10*BAUD_DIV cycles.
// Backpressure: none on RX (each word shown once); TX accepts only when idle, requests while busy are dropped.
// Optional: define UART_WORD_BRIDGE_RX_TIMEOUT_EN to discard a partial RX word after 32 idle bit times.
module uart_word_bridge #(
  parameter int BAUD_DIV   = 5207,
  parameter int DATA_WIDTH = 32,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_din,
  output logic                  uart_dout,
  output logic [DATA_WIDTH-1:0] high_read_data,
  output logic                  high_read_valid,
  input  logic [DATA_WIDTH-1:0] high_write_data,
  input  logic                  high_write_valid,
  output logic                  high_write_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [15:0]    BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0]    HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Byte lane of the idx-th byte on the wire within the word.
  function automatic int slot(input logic [BCW-1:0] idx);
    slot = (MSB_FIRST != 0) ? (BYTES - 1 - int'(idx)) : int'(idx);
  endfunction

  // ---------------------------------------------------------------- RX
  logic rx_meta, rx_sync, rx_prev;
  state_t rx_state, rx_next;
  logic [15:0]           rx_cnt;
  logic [2:0]            rx_bit;
  logic [7:0]            rx_shift;
  logic [BCW-1:0]        rx_byte;
  logic [DATA_WIDTH-1:0] rx_word, rx_word_next;
  logic                  rx_tick, rx_accept, rx_timeout;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_din;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= IDLE;
    else     rx_state <= rx_next;
  end

  // RX next state: half-bit wait to centre on the start bit, then one sample per bit time.
  always_comb begin
    rx_next   = rx_state;
    rx_tick   = 1'b0;
    rx_accept = 1'b0;
    case (rx_state)
      IDLE:  if (!rx_sync && rx_prev) rx_next = START;
      START: if (rx_cnt == HALF_LAST) begin
               rx_tick = 1'b1;
               rx_next = rx_sync ? IDLE : DATA;
             end
      DATA:  if (rx_cnt == BAUD_LAST) begin
               rx_tick = 1'b1;
               if (rx_bit == 3'd7) rx_next = STOP;
             end
      STOP:  if (rx_cnt == BAUD_LAST) begin
               rx_tick   = 1'b1;
               rx_next   = IDLE;
               rx_accept = rx_sync;
             end
      default: rx_next = IDLE;
    endcase
  end

  // Word with the just-received byte dropped into its lane.
  always_comb begin
    rx_word_next = rx_word;
    rx_word_next[slot(rx_byte)*8 +: 8] = rx_shift;
  end

  // RX datapath: bit timing, shift register, byte packing and the read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt          <= '0;
      rx_bit          <= '0;
      rx_shift        <= '0;
      rx_byte         <= '0;
      rx_word         <= '0;
      high_read_data  <= '0;
      high_read_valid <= 1'b0;
    end else begin
      high_read_valid <= 1'b0;
      rx_cnt <= (rx_state == IDLE || rx_tick) ? 16'd0 : rx_cnt + 16'd1;
      if (rx_state == START) rx_bit <= '0;
      if (rx_state == DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
      if (rx_accept) begin
        rx_word <= rx_word_next;
        if (rx_byte == LAST_BYTE) begin
          rx_byte         <= '0;
          high_read_data  <= rx_word_next;
          high_read_valid <= 1'b1;
        end else begin
          rx_byte <= rx_byte + 1'b1;
        end
      end else if (rx_timeout) begin
        rx_byte <= '0;
      end
    end
  end

`ifdef UART_WORD_BRIDGE_RX_TIMEOUT_EN
  localparam logic [21:0] TO_LAST = 22'(32 * BAUD_DIV - 1);
  logic [21:0] to_cnt;

  // Count idle-high cycles while a word is partly assembled; any activity restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= '0;
    else if (rx_state == IDLE && rx_sync && rx_byte != '0 && to_cnt != TO_LAST) to_cnt <= to_cnt + 22'd1;
    else to_cnt <= '0;
  end

  assign rx_timeout = (to_cnt == TO_LAST);
`else
  assign rx_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------- TX
  state_t tx_state, tx_next;
  logic [15:0]           tx_cnt;
  logic [2:0]            tx_bit;
  logic [BCW-1:0]        tx_byte, tx_idx;
  logic [DATA_WIDTH-1:0] tx_word, tx_src;
  logic [9:0]            tx_frame;
  logic [7:0]            tx_sel;
  logic                  tx_tick;

  assign tx_tick          = (tx_cnt == BAUD_LAST);
  assign high_write_ready = (tx_state == IDLE);
  assign uart_dout        = tx_frame[0];

  // TX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_next;
  end

  // TX next state: frames run back to back until the last byte's stop bit ends.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:  if (high_write_valid) tx_next = START;
      START: if (tx_tick) tx_next = DATA;
      DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
      STOP:  if (tx_tick) tx_next = (tx_byte == LAST_BYTE) ? IDLE : START;
      default: tx_next = IDLE;
    endcase
  end

  // Select the byte for the frame about to be loaded: byte 0 of the incoming word, or the next latched byte.
  always_comb begin
    tx_src = (tx_state == IDLE) ? high_write_data : tx_word;
    tx_idx = (tx_state == IDLE) ? '0 : tx_byte + 1'b1;
    tx_sel = tx_src[slot(tx_idx)*8 +: 8];
  end

  // TX datapath: a 10-bit frame shifts out LSB first; vacated bits fill with 1 so the line idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_word  <= '0;
      tx_frame <= '1;
    end else if (tx_state == IDLE) begin
      tx_cnt <= '0;
      if (high_write_valid) begin
        tx_word  <= high_write_data;
        tx_byte  <= '0;
        tx_bit   <= '0;
        tx_frame <= {1'b1, tx_sel, 1'b0};
      end
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_state == STOP && tx_next == START) begin
        tx_byte  <= tx_byte + 1'b1;
        tx_bit   <= '0;
        tx_frame <= {1'b1, tx_sel, 1'b0};
      end else begin
        tx_frame <= {1'b1, tx_frame[9:1]};
        if (tx_state == DATA) tx_bit <= tx_bit + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Bench for uart_word_bridge: two instances (MSB_FIRST=1 and 0) share the RX line;
// TX is exercised on the MSB_FIRST=1 instance and decoded back into bytes.
module tb_uart_word_bridge;
  localparam int BAUD   = 16;
  localparam int TO_CYC = 32 * BAUD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b1;
  logic [31:0] wdata = '0;
  logic wvalid = 1'b0;
  logic [31:0] lsb_wd = '0;
  logic lsb_wv = 1'b0;
  logic dout_m, dout_l, rv_m, rv_l, wr_m, wr_l;
  logic [31:0] rd_m, rd_l;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_m[$];
  logic [31:0] exp_l[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  part[$];
  bit tx_ignore = 1'b0;

  always #5 clk = ~clk;

  uart_word_bridge #(.BAUD_DIV(BAUD), .DATA_WIDTH(32), .MSB_FIRST(1)) u_m (
    .clk(clk), .rst(rst), .uart_din(din), .uart_dout(dout_m),
    .high_read_data(rd_m), .high_read_valid(rv_m),
    .high_write_data(wdata), .high_write_valid(wvalid), .high_write_ready(wr_m));

  uart_word_bridge #(.BAUD_DIV(BAUD), .DATA_WIDTH(32), .MSB_FIRST(0)) u_l (
    .clk(clk), .rst(rst), .uart_din(din), .uart_dout(dout_l),
    .high_read_data(rd_l), .high_read_valid(rv_l),
    .high_write_data(lsb_wd), .high_write_valid(lsb_wv), .high_write_ready(wr_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: every fourth good byte forms a word; order depends only on MSB_FIRST.
  task automatic model_byte(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == 4) begin
      exp_m.push_back({part[0], part[1], part[2], part[3]});
      exp_l.push_back({part[3], part[2], part[1], part[0]});
      part.delete();
    end
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
`ifdef UART_WORD_BRIDGE_RX_TIMEOUT_EN
    if (n > TO_CYC) part.delete();
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    din = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (BAUD) @(negedge clk);
    end
    if (stop_ok) model_byte(b);
    din = stop_ok;
    repeat (BAUD) @(negedge clk);
    idle(gap);
  endtask

  task automatic glitch(input int w);
    din = 1'b0;
    repeat (w) @(negedge clk);
    idle(20);
  endtask

  task automatic flush_rx();
    while (part.size() != 0) send_byte(8'($urandom), 1'b1, 2);
  endtask

  task automatic write_word(input logic [31:0] w);
    int n;
    check("tx_ready_before_write", 32'(wr_m), 32'd1);
    exp_tx.push_back(w[31:24]);
    exp_tx.push_back(w[23:16]);
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
    wdata  = w;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    n = 0;
    while (wr_m === 1'b0 && n < 1000) begin
      if (n == 100) begin
        wdata  = ~w;
        wvalid = 1'b1;
      end
      if (n == 105) wvalid = 1'b0;
      @(negedge clk);
      n++;
    end
    wvalid = 1'b0;
    check("tx_busy_cycles", 32'(n), 32'd640);
  endtask

  // Read-side monitors: every strobe must match the next modelled word.
  always @(negedge clk) begin
    if (!rst && rv_m) begin
      if (exp_m.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_word_msb: unexpected strobe with data 0x%0h, expected none", rd_m);
      end else check("rx_word_msb", rd_m, exp_m.pop_front());
    end
    if (!rst && rv_l) begin
      if (exp_l.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_word_lsb: unexpected strobe with data 0x%0h, expected none", rd_l);
      end else check("rx_word_lsb", rd_l, exp_l.pop_front());
    end
  end

  // TX line decoder: samples mid-bit and compares each frame with the expected byte stream.
  initial begin : tx_dec
    logic [7:0] b;
    logic sb, st;
    forever begin
      @(negedge clk);
      if (!rst && dout_m === 1'b0) begin
        repeat (7) @(negedge clk);
        st = dout_m;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = dout_m;
        end
        repeat (BAUD) @(negedge clk);
        sb = dout_m;
        if (!tx_ignore && st == 1'b0) begin
          if (exp_tx.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL tx_frame: unexpected byte 0x%0h, expected no frame", b);
          end else begin
            check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            check("tx_stop_bit", 32'(sb), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout_m), 32'd1);
    check("rst_read_valid", 32'(rv_m), 32'd0);
    check("rst_read_data", rd_m, 32'd0);
    check("rst_write_ready", 32'(wr_m), 32'd1);
    check("rst_dout_lsb", 32'(dout_l), 32'd1);
    check("rst_read_valid_lsb", 32'(rv_l), 32'd0);
    check("rst_read_data_lsb", rd_l, 32'd0);
    check("rst_write_ready_lsb", 32'(wr_l), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic word in both byte orders.
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    send_byte(8'h56, 1'b1, 0);
    send_byte(8'h78, 1'b1, 10);

    // Framing error byte is dropped without advancing the byte count.
    send_byte(8'h55, 1'b0, 4);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'h04, 1'b1, 10);

    // Short low pulse is not a start bit.
    glitch(6);
    send_byte(8'hC0, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'hEE, 1'b1, 0);
    send_byte(8'h11, 1'b1, 10);

    // Long idle in the middle of a word.
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'hBB, 1'b1, 0);
    idle(600);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'h04, 1'b1, 10);
    flush_rx();
    idle(20);

    // Transmit, with a dropped request while busy.
    write_word(32'hA1B2C3D4);
    idle(20);

    // Simultaneous TX and RX with random data.
    repeat (3) begin
      w = $urandom;
      fork
        write_word(w);
        begin
          repeat (4) send_byte(8'($urandom), 1'b1, $urandom_range(0, 20));
        end
      join
      idle(20);
    end

    // Random RX mix of good frames, framing errors and glitches.
    repeat (24) begin
      case ($urandom_range(0, 7))
        0:       glitch($urandom_range(1, 6));
        1:       send_byte(8'($urandom), 1'b0, $urandom_range(4, 30));
        default: send_byte(8'($urandom), 1'b1, $urandom_range(0, 40));
      endcase
    end
    flush_rx();
    idle(20);

    // Reset in the middle of TX byte 2 with a partial RX word pending.
    send_byte(8'hAA, 1'b1, 2);
    send_byte(8'hBB, 1'b1, 2);
    tx_ignore = 1'b1;
    wdata  = 32'h5A5AA5A5;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (2 * 160 + 40) @(negedge clk);
    rst = 1'b1;
    part.delete();
    #1;
    check("midtx_rst_dout", 32'(dout_m), 32'd1);
    check("midtx_rst_write_ready", 32'(wr_m), 32'd1);
    @(negedge clk);
    check("midtx_rst_read_valid", 32'(rv_m), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tx_ignore = 1'b0;
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 0);
    send_byte(8'hBE, 1'b1, 0);
    send_byte(8'hEF, 1'b1, 10);

    repeat (100) @(negedge clk);
    check("rx_msb_words_outstanding", 32'(exp_m.size()), 32'd0);
    check("rx_lsb_words_outstanding", 32'(exp_l.size()), 32'd0);
    check("tx_bytes_outstanding", 32'(exp_tx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_word_bridge.md
UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter BAUD_DIV, default 5207: clk cycles per UART bit; legal range 4..65535.
REQ-003 Parameter DATA_WIDTH, default 32: high-side word width; multiple of 8, range 8..64; BYTES = DATA_WIDTH/8.
REQ-004 Parameter MSB_FIRST, default 1: 1 = first UART byte maps to bits [DATA_WIDTH-1:DATA_WIDTH-8]; 0 = first byte maps to bits [7:0].
REQ-005 Ports, in order (name, direction, width, meaning):
- clk  input  1  system clock.
- rst  input  1  async active-high reset.
- uart_din  input  1  UART RX line, asynchronous, idle high.
- uart_dout  output  1  UART TX line, idle high.
- high_read_data  output  DATA_WIDTH  word assembled from received bytes.
- high_read_valid  output  1  one-cycle strobe qualifying high_read_data.
- high_write_data  input  DATA_WIDTH  word to transmit.
- high_write_valid  input  1  write request.
- high_write_ready  output  1  transmitter can accept a word.

Function
REQ-006 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV clk cycles.
REQ-007 uart_din SHALL pass through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-008 RX FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
- START: after BAUD_DIV/2 cycles, sample; 1 -> IDLE (glitch, no byte); 0 -> DATA.
- DATA: sample every BAUD_DIV cycles, 8 samples, then -> STOP.
- STOP: sample after BAUD_DIV cycles; 1 -> byte accepted; 0 -> framing error, byte discarded, byte count unchanged. Both outcomes -> IDLE.
REQ-009 Accepted bytes SHALL be packed into a word register per MSB_FIRST; a byte counter runs 0..BYTES-1 and wraps to 0.
REQ-010 When byte BYTES is accepted, high_read_data SHALL update and high_read_valid SHALL be 1 for exactly one cycle, the cycle after the stop-bit sample. high_read_data holds its value until the next word.
REQ-011 There is no RX backpressure; each word is presented once.
REQ-012 TX FSM states SHALL be IDLE, START, DATA, STOP. high_write_ready = 1 only in IDLE.
REQ-013 A word is accepted when high_write_valid && high_write_ready at a clk edge. The word is latched and high_write_ready is 0 from the next cycle.
REQ-014 Accepted words SHALL be sent as BYTES back-to-back frames with no idle gap, byte order per MSB_FIRST.
REQ-015 high_write_ready SHALL return to 1 on the cycle after the final stop bit completes; total busy time = BYTES*10*BAUD_DIV cycles.
REQ-016 high_write_valid while high_write_ready=0 SHALL be ignored; the word is not queued.
REQ-017 RX and TX SHALL be fully independent and may run simultaneously; high_read_valid may be looped directly to high_write_valid.

Reset
REQ-018 While rst=1, both FSMs SHALL be in IDLE, the byte counter and baud counters 0, and the word registers 0.
REQ-019 Output values during reset: uart_dout=1, high_read_valid=0, high_read_data=0, high_write_ready=1.
REQ-020 Reset asserted mid-frame SHALL abort both RX and TX immediately: uart_dout goes to 1 asynchronously and any partial word is discarded.

Configuration
REQ-021 With macro UART_WORD_BRIDGE_RX_TIMEOUT_EN defined, an RX idle of 32*BAUD_DIV cycles (line high, FSM in IDLE) while byte counter != 0 SHALL reset the byte counter to 0, discarding the partial word.
REQ-022 Without the macro, a partial word SHALL persist indefinitely, and the timeout counter logic SHALL NOT be synthesized.

Verification (BAUD_DIV=16, DATA_WIDTH=32 unless stated)
REQ-023 RX 0x12,0x34,0x56,0x78 with MSB_FIRST=1 -> single-cycle high_read_valid, high_read_data=0x12345678; with MSB_FIRST=0 -> 0x78563412.
REQ-024 Write 0xA1B2C3D4 (MSB_FIRST=1) -> uart_dout frames A1,B2,C3,D4; high_write_ready low for exactly 640 cycles; a second valid during busy produces no extra frames.
REQ-025 RX byte 0x55 with stop bit 0, then 0x01,0x02,0x03,0x04 -> exactly one word, 0x01020304.
REQ-026 uart_din low pulse of 6 cycles -> no byte, no valid; a following valid frame decodes correctly.
REQ-027 RX 0xAA,0xBB, idle 600 cycles, then 0x01,0x02,0x03,0x04 -> with macro: 0x01020304 only; without macro: 0xAABB0102 (0x0304 remains partial).
REQ-028 Assert rst mid-TX at byte 2 -> uart_dout=1 in the same cycle and high_write_ready=1; after release, RX packing restarts from byte 0.
